// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: non-shift ops finish in 1 cycle, shifts step one bit per cycle (k+1 cycles).
// Result is held in DONE until out_ready; new ops are accepted only in IDLE.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucon,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t          state_q;
    shkind_t         shkind_q;
    shkind_t         shkind_d;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;

    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] step_d;
    logic            illegal_d;
    logic            is_shift_d;
    logic [SHW-1:0]  amt;

    assign amt = op_b[SHW-1:0];

    // Single-cycle result for the offered op; shifts pass op_a through so k=0 needs no special path.
    always_comb begin
        alu_d      = '0;
        illegal_d  = 1'b0;
        is_shift_d = 1'b0;
        shkind_d   = SH_LL;
        case (alucon)
            4'b0000: alu_d = op_a + op_b;
            4'b1000: alu_d = op_a - op_b;
            4'b0010: alu_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b0011: alu_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b0100: alu_d = op_a ^ op_b;
            4'b0110: alu_d = op_a | op_b;
            4'b0111: alu_d = op_a & op_b;
            4'b0001: begin alu_d = op_a; is_shift_d = 1'b1; shkind_d = SH_LL; end
            4'b0101: begin alu_d = op_a; is_shift_d = 1'b1; shkind_d = SH_RL; end
            4'b1101: begin alu_d = op_a; is_shift_d = 1'b1; shkind_d = SH_RA; end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        step_d = result_q;
        case (shkind_q)
            SH_LL:   step_d = {result_q[XLEN-2:0], 1'b0};
            SH_RL:   step_d = {1'b0, result_q[XLEN-1:1]};
            SH_RA:   step_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: step_d = result_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shkind_q  <= SH_LL;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift_d && (amt != '0)) begin
                            result_q  <= op_a;
                            cnt_q     <= amt;
                            shkind_q  <= shkind_d;
                            illegal_q <= 1'b0;
                            state_q   <= ST_SHIFT;
                        end else begin
                            result_q  <= alu_d;
                            zero_q    <= (alu_d == '0);
                            illegal_q <= illegal_d;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= step_d;
                    cnt_q    <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        zero_q  <= (step_d == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, corner-case sequences and randomized ops against a reference model.
module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      alucon = 4'd0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_exec_unit #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alucon(alucon), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain operator semantics, latency from the shift amount.
    function automatic void ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic ill, output int lat);
        int k;
        k   = int'(b[4:0]);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        case (c)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b0001: begin r = a << k; lat = k + 1; end
            4'b0101: begin r = a >> k; lat = k + 1; end
            4'b1101: begin r = 32'($signed(a) >>> k); lat = k + 1; end
            default: ill = 1'b1;
        endcase
    endfunction

    // One op from IDLE: accept, measure latency, check outputs, then drain.
    task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ei, input int elat);
        int lat;
        @(negedge clk);
        chk({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; alucon = c; op_a = a; op_b = b; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alucon = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " result"}, {32'd0, result}, {32'd0, er});
        chk({nm, " zero"}, {63'd0, zero}, {63'd0, (er == 32'd0)});
        chk({nm, " illegal"}, {63'd0, illegal}, {63'd0, ei});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " drained"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        logic        ill;
        int          lat;
        logic [31:0] held;
        logic [31:0] bb_a[3];
        logic [31:0] bb_b[3];
        logic [3:0]  bb_c[3];
        logic [31:0] bb_e[3];

        vecs.push_back('{"add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1});
        vecs.push_back('{"sub_neg", 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1});
        vecs.push_back('{"slt", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1});
        vecs.push_back('{"sltu", 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1});
        vecs.push_back('{"sll31", 4'b0001, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32});
        vecs.push_back('{"sra4", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5});
        vecs.push_back('{"srl4", 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5});
        vecs.push_back('{"sll0", 4'b0001, 32'hA5A5_1234, 32'h20, 32'hA5A5_1234, 1'b0, 1});
        vecs.push_back('{"illegal1010", 4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1});
        vecs.push_back('{"illegal1111", 4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1});
        vecs.push_back('{"xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1});

        // Reset values
        #1;
        chk("reset outs", {30'd0, result, out_valid, busy}, 64'd0);
        chk("reset flags", {62'd0, zero, illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_ill, vecs[i].exp_lat);

        // Reset in the middle of a long arithmetic shift
        @(negedge clk);
        in_valid = 1'b1; alucon = 4'b1101; op_a = 32'h8000_0000; op_b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midshift busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midshift reset outs", {30'd0, result, out_valid, busy}, 64'd0);
        chk("midshift reset flags", {61'd0, zero, illegal, in_ready}, 64'b001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midshift release in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("midshift stays idle", {62'd0, out_valid, busy}, 64'd0);

        // Backpressure: DONE holds while inputs churn
        @(negedge clk);
        in_valid = 1'b1; alucon = 4'b0000; op_a = 32'd100; op_b = 32'd23;
        @(negedge clk);
        held = 32'd123;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid; op_a = $urandom; op_b = $urandom;
            @(negedge clk);
            chk("bp hold", {30'd0, result, out_valid, in_ready}, {30'd0, held, 2'b10});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release", {62'd0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        chk("bp nothing accepted", {62'd0, out_valid, busy}, 64'd0);

        // Back-to-back bitwise ops with in_valid held high
        bb_c[0] = 4'b0111; bb_a[0] = 32'hFF00_FF00; bb_b[0] = 32'h0FF0_0FF0;
        bb_c[1] = 4'b0110; bb_a[1] = 32'h1200_0034; bb_b[1] = 32'h0056_7800;
        bb_c[2] = 4'b0100; bb_a[2] = 32'hAAAA_5555; bb_b[2] = 32'hFFFF_0000;
        bb_e[0] = 32'h0F00_0F00; bb_e[1] = 32'h1256_7834; bb_e[2] = 32'h5555_5555;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        alucon = bb_c[0]; op_a = bb_a[0]; op_b = bb_b[0];
        for (int i = 0; i < 3; i++) begin
            chk("b2b in_ready", {63'd0, in_ready}, 64'd1);
            @(negedge clk);
            if (i < 2) begin
                alucon = bb_c[i+1]; op_a = bb_a[i+1]; op_b = bb_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
            chk("b2b result", {31'd0, out_valid, result}, {31'd0, 1'b1, bb_e[i]});
            chk("b2b busy", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("b2b idle", {62'd0, out_valid, in_ready}, 64'b01);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (($urandom_range(0, 7) == 0)) a = b;
            ref_model(c, a, b, r, ill, lat);
            run_op($sformatf("rand%0d_op%0h", i, c), c, a, b, r, ill, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
